// File: rtl/gcounter_param.sv
// Parametrised Gray/binary up-down counter with load, wrap-or-saturate policy
// and a registered limit-event pulse. All outputs come straight from flops.
module gcounter_param #(
    parameter int unsigned WIDTH = 32,
    parameter bit          GRAY  = 1'b1,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] bin,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = '0;

    // Output encoding of a binary value: reflected Gray or pass-through.
    function automatic logic [WIDTH-1:0] code(input logic [WIDTH-1:0] x);
        if (GRAY) begin
            return x ^ (x >> 1);
        end
        return x;
    endfunction

    logic [WIDTH-1:0] bin_nxt;
    logic             ovf_nxt;
    logic             at_max;
    logic             at_min;
    logic             past_limit;

    assign at_max     = (bin == MAX_VAL);
    assign at_min     = (bin == MIN_VAL);
    assign past_limit = up ? at_max : at_min;

    // Next binary value and limit-event flag; priority is load, then en.
    always_comb begin
        bin_nxt = bin;
        ovf_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_val;
        end else if (en) begin
            if (past_limit) begin
                ovf_nxt = 1'b1;
                if (WRAP) begin
                    bin_nxt = up ? MIN_VAL : MAX_VAL;
                end
            end else begin
                bin_nxt = up ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
            end
        end
    end

    // q and bin share one state update so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin <= '0;
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            bin <= bin_nxt;
            q   <= code(bin_nxt);
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: doc/gcounter_param.md
Name: gcounter_param

Overview:
Parametrised Gray-code counter, the successor to the fixed 32-bit gcounter32. It adds configurable width, count enable, up/down direction, synchronous load, and a wrap-or-saturate policy. An overflow pulse is registered alongside the count. The block serves as the low-toggle counter primitive in the counter/power-characterisation experiments, where the Gray output keeps output switching activity to one bit per step.

Parameters:
WIDTH, 32, counter width in bits (>= 2)
GRAY, 1, 1 = q presents the Gray code of the count; 0 = q presents plain binary (baseline for power comparison)
WRAP, 1, 1 = modulo-2^WIDTH wrap at the limits; 0 = saturate at the limits

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; one step per cycle while high
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe
load_val  input  WIDTH  binary value to load
q  output  WIDTH  registered count: Gray (GRAY=1) or binary (GRAY=0)
bin  output  WIDTH  registered binary count
ovf  output  1  registered one-cycle pulse flagging a limit event

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. While reset is sampled high at a rising edge, bin=0, q=0 and ovf=0 after that edge. Reset has top priority and may be asserted mid-count.
- Priority at each edge: reset, then load, then en. With none of them active, bin and q hold and ovf=0.
- Load: bin <= load_val and q <= code(load_val), where code(x) = x ^ (x>>1) if GRAY=1, otherwise x. Load takes priority over a simultaneous en. ovf=0 on a load cycle.
- Count: when en=1 and load=0:
  - up=1: bin <= bin+1
  - up=0: bin <= bin-1
  - q <= code of the new bin. Latency is one cycle: q reflects the step at the edge that sampled en.
- Limits: the up limit is all-ones; the down limit is 0.
  - WRAP=1, stepping past a limit: bin wraps (all-ones -> 0 going up, 0 -> all-ones going down), and ovf=1 in the same cycle q shows the wrapped value.
  - WRAP=0, stepping past a limit: bin and q hold at the limit, and ovf=1 for every cycle a step is attempted past the limit.
- ovf is otherwise 0. It is never asserted on reset, load or idle cycles.
- Direction may change on any cycle with no penalty. The next step uses the newly sampled up value.
- Invariant, GRAY=1 and WRAP=1: across consecutive en=1 count cycles, q changes in exactly one bit, including across the wrap.
- q and bin are both registered from the same state update; no output has a combinational path from an input.
- X-safety: en, up and load are ignored while reset=1.

Test Plan:
1. WIDTH=4, GRAY=1: reset for 3 cycles, then en=1, up=1 for 20 cycles -> q = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000,... The single-bit-change check holds every cycle; ovf=1 only in the cycle q returns to 0000.
2. WIDTH=4: load=1, load_val=0101 -> next cycle bin=0101, q=0111. Then en=1, up=0 for 6 cycles -> bin=0100,0011,0010,0001,0000,1111; ovf=1 only when bin=1111.
3. WIDTH=4, WRAP=0: load 1110, en=1, up=1 for 4 cycles -> bin=1111,1111,1111,1111; ovf=0,1,1,1. Then up=0 -> bin=1110, ovf=0.
4. Simultaneous events: load=1 and en=1 with load_val=0011 -> bin=0011 (no step), ovf=0. Reset asserted mid-count together with load=1 -> bin=0, q=0, ovf=0.
5. WIDTH=32, GRAY=0: reset 3 cycles, en=1 for 200 cycles -> q = bin = 0..199 in order, ovf=0 throughout. Then load 0xFFFFFFFE with up=1 for 2 steps -> 0xFFFFFFFF, then 0x00000000 with ovf=1.
6. en=0 for 10 cycles mid-count at bin=7 -> q and bin hold 7, ovf=0. Toggling up on alternate cycles with en=1 -> bin alternates 8,7,8,7.
